// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi test-link frame sequencer.
package viterbi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        TAIL,
        DRAIN,
        DONE
    } link_state_e;

    localparam int unsigned CNT_W = 16;

    // x^16+x^14+x^13+x^11+1 as a right-shifting Fibonacci register: feedback from bits 0,2,3,5
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/viterbi_err_lfsr.sv
// 16-bit Fibonacci LFSR that schedules channel symbol flips; seeded on reset only.
module viterbi_err_lfsr
    import viterbi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= LFSR_SEED;
        end else if (adv) begin
            q <= {^(q & LFSR_TAPS), q[15:1]};
        end
    end

endmodule

// File: rtl/viterbi_link_ctrl.sv
// Frame sequencer, error-injection scheduler and bit-error counter for the Viterbi test link.
module viterbi_link_ctrl
    import viterbi_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 32,
    parameter int unsigned TAIL_LEN  = 2,
    parameter int unsigned DEC_LAT   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [FRAME_LEN-1:0] frame_i,
    input  logic [7:0]           err_thresh_i,
    output logic                 enc_enable_o,
    output logic                 enc_bit_o,
    output logic [1:0]           inj_flip_o,
    input  logic                 dec_bit_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_W-1:0]     bit_err_ct_o,
    output logic [CNT_W-1:0]     inj_ct_o
);

    localparam int unsigned      IW         = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] SEND_LAST  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] TAIL_LAST  = CNT_W'(FRAME_LEN + TAIL_LEN - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DEC_LAT + FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] WIN_LO     = CNT_W'(DEC_LAT);

    link_state_e          state;
    logic [FRAME_LEN-1:0] frame;
    logic [CNT_W-1:0]     cyc;
    logic [15:0]          lfsr_q;
    logic                 adv;
    logic                 in_win;
    logic                 bit_err;
    logic                 inj_hit;
    logic                 unused_lfsr;

    assign unused_lfsr = ^lfsr_q[15:9];

    viterbi_err_lfsr u_lfsr (
        .clk (clk),
        .rst (rst),
        .adv (adv),
        .q   (lfsr_q)
    );

    // Outputs are registered, so the LFSR steps at the edge entering each enabled cycle;
    // the flip registered there comes from the value that cycle owns.
    always_comb begin
        adv     = 1'b0;
        in_win  = (state inside {SEND, TAIL, DRAIN}) && (cyc >= WIN_LO) && (cyc <= DRAIN_LAST);
        bit_err = in_win && (dec_bit_i != frame[IW'(cyc - WIN_LO)]);
        inj_hit = lfsr_q[7:0] < err_thresh_i;
        unique case (state)
            IDLE:    adv = start_i;
            SEND:    adv = 1'b1;
            TAIL:    adv = (cyc != TAIL_LAST);
            default: adv = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            frame        <= '0;
            cyc          <= '0;
            enc_enable_o <= 1'b0;
            enc_bit_o    <= 1'b0;
            inj_flip_o   <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            bit_err_ct_o <= '0;
            inj_ct_o     <= '0;
        end else begin
            done_o     <= 1'b0;
            inj_flip_o <= (adv && inj_hit) ? (lfsr_q[8] ? 2'b10 : 2'b01) : 2'b00;

            if (state inside {SEND, TAIL, DRAIN}) begin
                cyc <= cyc + CNT_W'(1);
            end
            if (bit_err && (bit_err_ct_o != '1)) begin
                bit_err_ct_o <= bit_err_ct_o + CNT_W'(1);
            end
            if (enc_enable_o && (inj_flip_o != 2'b00) && (inj_ct_o != '1)) begin
                inj_ct_o <= inj_ct_o + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (start_i) begin
                        state        <= SEND;
                        frame        <= frame_i;
                        cyc          <= '0;
                        bit_err_ct_o <= '0;
                        inj_ct_o     <= '0;
                        enc_enable_o <= 1'b1;
                        enc_bit_o    <= frame_i[0];
                        busy_o       <= 1'b1;
                    end
                end
                SEND: begin
                    if (cyc == SEND_LAST) begin
                        state     <= TAIL;
                        enc_bit_o <= 1'b0;
                    end else begin
                        enc_bit_o <= frame[IW'(cyc + CNT_W'(1))];
                    end
                end
                TAIL: begin
                    if (cyc == TAIL_LAST) begin
                        state        <= DRAIN;
                        enc_enable_o <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (cyc >= DRAIN_LAST) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_link_ctrl.sv
// Self-checking bench for viterbi_link_ctrl: vector table, random frames and multi-cycle corner sequences.
module tb_viterbi_link_ctrl;

    localparam int F  = 32;
    localparam int T  = 2;
    localparam int DL = 16;

    typedef struct {
        logic [31:0] frame;
        logic [7:0]  thresh;
        logic [31:0] mask;     // data bits whose decoded copy is inverted
        bit          inv_out;  // also invert dec just before and just after the window
        bit          poke;     // pulse start with another frame while busy
        int          exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [31:0] frame_i;
    logic [7:0]  err_thresh_i;
    logic        enc_enable_o;
    logic        enc_bit_o;
    logic [1:0]  inj_flip_o;
    logic        dec_bit_i;
    logic        busy_o;
    logic        done_o;
    logic [15:0] bit_err_ct_o;
    logic [15:0] inj_ct_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc_ct   = 0;
    int          t_start  = -1000;
    logic [31:0] cur_mask;
    bit          cur_inv_out;
    logic [15:0] m_lfsr;
    bit          enc_q[$];
    vec_t        tbl[5];

    always #5 clk = ~clk;

    viterbi_link_ctrl #(
        .FRAME_LEN (F),
        .TAIL_LEN  (T),
        .DEC_LAT   (DL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .frame_i      (frame_i),
        .err_thresh_i (err_thresh_i),
        .enc_enable_o (enc_enable_o),
        .enc_bit_o    (enc_bit_o),
        .inj_flip_o   (inj_flip_o),
        .dec_bit_i    (dec_bit_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .bit_err_ct_o (bit_err_ct_o),
        .inj_ct_o     (inj_ct_o)
    );

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One clock; afterwards drive the decoder input as the encoder bit from 16 cycles earlier.
    task automatic step();
        int rel;
        bit inv;
        @(posedge clk);
        #1;
        cyc_ct++;
        if (rst) m_lfsr = 16'hACE1;
        enc_q.push_back(enc_bit_o);
        rel = cyc_ct + 1 - t_start;
        inv = 1'b0;
        if (rel >= DL + 1 && rel <= DL + F) inv = cur_mask[rel - DL - 1];
        if (cur_inv_out && (rel == DL || rel == F + DL + 1)) inv = 1'b1;
        dec_bit_i = (enc_q.size() > DL) ? (enc_q.pop_front() ^ inv) : inv;
    endtask

    // Starts a frame from an IDLE cycle and checks every cycle until the done pulse.
    task automatic run_frame(input vec_t v, input bit hold);
        logic [1:0] eflip;
        logic       en;
        logic       b;
        int         m_inj;
        m_inj        = 0;
        frame_i      = v.frame;
        err_thresh_i = v.thresh;
        start_i      = 1'b1;
        cur_mask     = v.mask;
        cur_inv_out  = v.inv_out;
        t_start      = cyc_ct + 1;
        step();
        if (!hold) start_i = 1'b0;
        for (int rel = 1; rel <= F + DL + 1; rel++) begin
            if (rel > 1) step();
            if (rel == 1) check("counters_clear_on_accept", {bit_err_ct_o, inj_ct_o}, 64'h0);
            en    = (rel <= F + T);
            b     = (rel <= F) ? v.frame[rel - 1] : 1'b0;
            eflip = 2'b00;
            if (en) begin
                if (m_lfsr[7:0] < v.thresh) begin
                    eflip = m_lfsr[8] ? 2'b10 : 2'b01;
                    m_inj++;
                end
                m_lfsr = lfsr_next(m_lfsr);
            end
            check($sformatf("outputs rel=%0d {en,bit,busy,done,flip}", rel),
                  {enc_enable_o, enc_bit_o, busy_o, done_o, inj_flip_o},
                  {en, b, (rel <= F + DL), (rel == F + DL + 1), eflip});
            if (v.poke && rel == 5) begin
                start_i = 1'b1;
                frame_i = ~v.frame;
            end
            if (v.poke && rel == 6) start_i = 1'b0;
        end
        check("bit_err_ct at done", bit_err_ct_o, v.exp_err);
        check("inj_ct at done", inj_ct_o, m_inj);
    endtask

    initial begin
        vec_t v;
        bit   seen_done;

        tbl[0] = '{32'hA5A5_0F0F, 8'h00, 32'h0000_0000, 1'b0, 1'b0, 0};
        tbl[1] = '{32'hA5A5_0F0F, 8'h00, 32'h8000_8001, 1'b1, 1'b0, 3};
        tbl[2] = '{32'hDEAD_BEEF, 8'hFF, 32'h0000_0000, 1'b0, 1'b0, 0};
        tbl[3] = '{32'h1234_5678, 8'h40, 32'hFFFF_FFFF, 1'b0, 1'b1, 32};
        tbl[4] = '{32'h0000_0001, 8'h01, 32'h0000_00F0, 1'b1, 1'b0, 4};

        rst          = 1'b1;
        start_i      = 1'b0;
        frame_i      = '0;
        err_thresh_i = '0;
        dec_bit_i    = 1'b0;
        cur_mask     = '0;
        cur_inv_out  = 1'b0;
        m_lfsr       = 16'hACE1;
        repeat (3) step();
        check("reset_state", {enc_enable_o, enc_bit_o, inj_flip_o, busy_o, done_o, bit_err_ct_o, inj_ct_o}, 64'h0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            run_frame(tbl[i], 1'b0);
            step();
            check($sformatf("idle_after_frame %0d", i), {done_o, busy_o, enc_enable_o}, 64'h0);
        end

        for (int i = 0; i < 6; i++) begin
            v.frame   = $urandom;
            v.thresh  = 8'($urandom_range(0, 255));
            v.mask    = $urandom & $urandom & $urandom;
            v.inv_out = 1'($urandom_range(0, 1));
            v.poke    = 1'($urandom_range(0, 1));
            v.exp_err = $countones(v.mask);
            run_frame(v, 1'b0);
            step();
        end

        // Reset while sending: everything clears, no done follows, LFSR restarts from seed.
        frame_i      = 32'hFFFF_0000;
        err_thresh_i = 8'hFF;
        cur_mask     = '0;
        cur_inv_out  = 1'b0;
        start_i      = 1'b1;
        t_start      = cyc_ct + 1;
        step();
        start_i = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("outputs_after_mid_reset", {enc_enable_o, enc_bit_o, inj_flip_o, busy_o, done_o, bit_err_ct_o, inj_ct_o}, 64'h0);
        seen_done = 1'b0;
        for (int i = 0; i < F + DL + 4; i++) begin
            step();
            if (done_o) seen_done = 1'b1;
        end
        check("no_done_after_mid_reset", seen_done, 1'b0);
        v = '{32'hC3C3_5A5A, 8'hFF, 32'h0000_0000, 1'b0, 1'b0, 0};
        run_frame(v, 1'b0);
        step();

        // Back-to-back with start held high across DONE.
        v = '{32'h0F0F_F0F0, 8'hFF, 32'h0000_0101, 1'b0, 1'b0, 2};
        run_frame(v, 1'b1);
        step();
        check("b2b_idle_gap", {enc_enable_o, busy_o, done_o}, 64'h0);
        check("b2b_counters_hold_in_idle", bit_err_ct_o, 16'd2);
        v = '{32'h8765_4321, 8'h80, 32'h0000_0000, 1'b0, 1'b0, 0};
        run_frame(v, 1'b0);
        step();

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/viterbi_link_ctrl.md
# viterbi_link_ctrl

Frame sequencer and error-injection scheduler for the Viterbi encoder/decoder test link. It accepts one parallel data frame and streams it LSB-first into the convolutional encoder, then appends zero tail bits to flush the encoder. An LFSR schedules single-bit symbol flips on the encoder-to-decoder channel. It compares decoder output against the sent bits at a fixed latency and reports bit-error and injection counts per frame.

## Interface
Parameters:
- FRAME_LEN, 32: data bits per frame.
- TAIL_LEN, 2: zero flush bits appended after the data bits, K-1 for a K=3 code.
- DEC_LAT, 16: cycles from `enc_bit_o` carrying bit j to `dec_bit_i` carrying decoded bit j. Must be at least TAIL_LEN.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  request to send a frame. Sampled only in IDLE.
- frame_i  in  FRAME_LEN  frame data, latched when start is accepted.
- err_thresh_i  in  8  injection rate. Inject when lfsr[7:0] < err_thresh_i. A value of 0 means never inject.
- enc_enable_o  out  1  encoder enable.
- enc_bit_o  out  1  encoder data bit.
- inj_flip_o  out  2  XOR mask the channel applies to the encoder symbol in the same cycle. Either 00 or one-hot.
- dec_bit_i  in  1  decoder output bit.
- busy_o  out  1  frame in progress.
- done_o  out  1  one-cycle pulse when the counters are final.
- bit_err_ct_o  out  16  data-bit mismatches this frame, saturating.
- inj_ct_o  out  16  injected flips this frame, saturating.

## Operation
- The FSM has five states: IDLE, SEND, TAIL, DRAIN and DONE.
- A 16-bit cycle counter `cyc` clears on start accept and increments every cycle in SEND, TAIL and DRAIN.
- IDLE:
  - When start_i=1, latch frame_i, clear both counters and `cyc`, and go to SEND.
  - start_i is ignored in every other state.
- SEND:
  - enc_enable_o=1 and enc_bit_o=frame[cyc].
  - Go to TAIL after `cyc`=FRAME_LEN-1.
- TAIL:
  - enc_enable_o=1 and enc_bit_o=0.
  - Go to DRAIN after `cyc`=FRAME_LEN+TAIL_LEN-1.
- DRAIN:
  - enc_enable_o=0 and enc_bit_o=0.
  - Go to DONE after `cyc`=DEC_LAT+FRAME_LEN-1.
- DONE:
  - done_o=1 and busy_o=0 for one cycle, then go to IDLE.
  - The counters hold until the next start is accepted.
- Compare window, `cyc` from DEC_LAT to DEC_LAT+FRAME_LEN-1:
  - If dec_bit_i differs from frame[cyc-DEC_LAT], increment bit_err_ct_o.
  - Tail bits are never compared.
  - The window overlaps SEND, TAIL and DRAIN as required.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset only. It is not reseeded per frame.
  - Advances only in cycles with enc_enable_o=1.
  - In such a cycle, when lfsr[7:0] < err_thresh_i, inj_flip_o = lfsr[8] ? 2'b10 : 2'b01 and inj_ct_o increments. Otherwise inj_flip_o=00.
  - inj_flip_o=00 whenever enc_enable_o=0.
- Counters saturate at 16'hFFFF and never wrap.
- Reset, including mid-frame:
  - State goes to IDLE.
  - All outputs and counters go to 0 and the LFSR goes to its seed.
  - Any partial frame is discarded.

## Timing
- Start is sampled at edge t.
- Bit j is driven on enc_bit_o in cycle t+1+j. Tail bits occupy cycles t+1+FRAME_LEN through t+FRAME_LEN+TAIL_LEN.
- dec_bit_i for bit j is sampled in cycle t+1+j+DEC_LAT.
- done_o pulses in cycle t+1+FRAME_LEN+DEC_LAT. With defaults that is t+49.
- busy_o is 1 from t+1 to t+FRAME_LEN+DEC_LAT.
- The next start is accepted in the cycle after done_o, which is IDLE. Start held high through DONE therefore starts the next frame exactly one cycle later.
- All outputs are registered: enc_enable_o, enc_bit_o and inj_flip_o come from flops, and the counters update at the edge ending the qualifying cycle.

## Structure
- Package `viterbi_pkg` holds:
  - the `link_state_e` enum (IDLE, SEND, TAIL, DRAIN, DONE);
  - the LFSR seed and tap constants;
  - the counter width constant.
- Sub-module `viterbi_err_lfsr` holds the 16-bit LFSR with `adv` and `q[15:0]` ports and shares clk/rst. The FSM, compare logic and counters stay in `viterbi_link_ctrl`.

## Test plan
1. Clean frame: err_thresh_i=0, frame_i=32'hA5A5_0F0F, dec_bit_i driven as enc_bit_o delayed 16 cycles.
   - bit_err_ct_o=0 and inj_ct_o=0.
   - done_o at t+49; enc_bit_o carries 1,1,1,1,0,0,0,0,... from t+1, followed by 2 zero tail bits.
2. Forced errors: as scenario 1, but the bench inverts dec_bit_i for bits 0, 15 and 31.
   - bit_err_ct_o=3.
   - Inverting dec_bit_i during a tail-aligned cycle outside the window adds no count.
3. Injection: err_thresh_i=8'hFF with a reference LFSR model in the bench.
   - inj_flip_o always 00 or one-hot, and exactly matches the model.
   - inj_ct_o equals the model's count over the 34 enabled cycles.
   - inj_flip_o=00 during DRAIN.
4. Start while busy: pulse start_i at t+5 with a different frame_i.
   - Ignored; the counters and sent bits reflect the original frame only.
5. Reset mid-SEND: assert rst at t+10 for one cycle.
   - Next cycle all outputs are 0 and no done_o follows.
   - A new start yields the same injection pattern as the first frame after power-on reset.
6. Back-to-back: start_i held high.
   - The second frame's enc_enable_o rises at t+51.
   - The counters clear on the second accept.
